// File: rtl/tiger_muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit.
// Also holds the small absolute-value helper used for the signed divide.
package tiger_muldiv_defines;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_e;

  typedef enum logic [1:0] {
    MD_ST_IDLE = 2'd0,
    MD_ST_MUL  = 2'd1,
    MD_ST_DIV  = 2'd2
  } md_state_e;

  localparam int DIV_ITER = 32;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/tiger_muldiv_divider.sv
// Unsigned 32/32 restoring divider: one quotient bit per clock, 32 iterations.
// done holds from the last iteration until the cycle after, then the unit goes idle.
module tiger_divider
  import tiger_muldiv_defines::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic        r_run;
  logic [5:0]  r_cnt;
  logic [31:0] r_quo;
  logic [31:0] r_rem;
  logic [31:0] r_dvs;

  logic [32:0] w_shift;
  logic [33:0] w_sub;
  logic        w_ge;

  // Partial remainder shifted left with the next dividend bit; a borrow means restore.
  assign w_shift = {r_rem, r_quo[31]};
  assign w_sub   = {1'b0, w_shift} - {2'b00, r_dvs};
  assign w_ge    = ~w_sub[33];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_run <= 1'b0;
      r_cnt <= '0;
      r_quo <= '0;
      r_rem <= '0;
      r_dvs <= '0;
    end else if (start) begin
      r_run <= 1'b1;
      r_cnt <= '0;
      r_quo <= dividend;
      r_rem <= '0;
      r_dvs <= divisor;
    end else if (r_run) begin
      if (r_cnt != 6'(DIV_ITER)) begin
        r_quo <= {r_quo[30:0], w_ge};
        r_rem <= w_ge ? w_sub[31:0] : w_shift[31:0];
        r_cnt <= r_cnt + 6'd1;
      end else begin
        r_run <= 1'b0;
      end
    end
  end

  assign done      = r_run && (r_cnt == 6'(DIV_ITER));
  assign quotient  = r_quo;
  assign remainder = r_rem;

endmodule

// File: rtl/tiger_muldiv.sv
// HI/LO multiply/divide unit in Execute: multi-cycle MULT/DIV, MTxx/MFxx access,
// and an Ex stall request whenever a HI/LO op meets a busy unit.
module tiger_muldiv
  import tiger_muldiv_defines::*;
#(
  parameter int MUL_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  mdOp,
  input  logic [31:0] rsVal,
  input  logic [31:0] rtVal,
  input  logic        stallMA,
  output logic        stallRqEx,
  output logic [31:0] mdResult,
  output logic        busy
);

  localparam int MC_W = $clog2(MUL_CYCLES + 1);

  md_op_e      w_op;
  md_state_e   r_state, w_state_nxt;
  logic [31:0] r_hi, r_lo;
  logic [MC_W-1:0] r_mul_cnt;
  logic [63:0] r_prod [MUL_CYCLES];
  logic        r_neg_q, r_neg_r, r_dbz;
  logic [31:0] r_dvd_raw;

  logic        w_accept, w_is_mul, w_is_div, w_mul_sgn, w_div_sgn;
  logic        w_mul_done, w_div_fin, w_div_done;
  logic [63:0] w_prod;
  logic [31:0] w_dvd_abs, w_dvs_abs, w_quo, w_rem, w_q_fix, w_r_fix;

  assign w_op     = md_op_e'(mdOp);
  assign w_is_mul = (w_op == MD_MULT) || (w_op == MD_MULTU);
  assign w_is_div = (w_op == MD_DIV)  || (w_op == MD_DIVU);
  assign w_accept = (r_state == MD_ST_IDLE) && !stallMA &&
                    (w_is_mul || w_is_div || w_op == MD_MTHI || w_op == MD_MTLO);

  // Sign-extend only for MULT so one 64-bit multiply serves both flavours.
  assign w_mul_sgn = (w_op == MD_MULT);
  assign w_prod    = {{32{w_mul_sgn & rsVal[31]}}, rsVal} * {{32{w_mul_sgn & rtVal[31]}}, rtVal};

  assign w_div_sgn = (w_op == MD_DIV);
  assign w_dvd_abs = w_div_sgn ? abs32(rsVal) : rsVal;
  assign w_dvs_abs = w_div_sgn ? abs32(rtVal) : rtVal;

  tiger_divider u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (w_accept && w_is_div),
    .dividend  (w_dvd_abs),
    .divisor   (w_dvs_abs),
    .done      (w_div_fin),
    .quotient  (w_quo),
    .remainder (w_rem)
  );

  assign w_mul_done = (r_state == MD_ST_MUL) && (r_mul_cnt == MC_W'(MUL_CYCLES));
  assign w_div_done = (r_state == MD_ST_DIV) && w_div_fin;

  // Divide-by-zero bypasses the sign fix-up: LO all ones, HI the raw dividend.
  assign w_q_fix = r_dbz ? 32'hFFFF_FFFF : (r_neg_q ? (~w_quo + 32'd1) : w_quo);
  assign w_r_fix = r_dbz ? r_dvd_raw     : (r_neg_r ? (~w_rem + 32'd1) : w_rem);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= MD_ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MD_ST_IDLE: begin
        if (w_accept && w_is_mul)      w_state_nxt = MD_ST_MUL;
        else if (w_accept && w_is_div) w_state_nxt = MD_ST_DIV;
      end
      MD_ST_MUL: if (w_mul_done) w_state_nxt = MD_ST_IDLE;
      MD_ST_DIV: if (w_div_done) w_state_nxt = MD_ST_IDLE;
      default:   w_state_nxt = MD_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mul_cnt <= '0;
      for (int i = 0; i < MUL_CYCLES; i++) r_prod[i] <= '0;
    end else begin
      if (w_accept && w_is_mul) r_prod[0] <= w_prod;
      for (int i = MUL_CYCLES - 1; i > 0; i--) r_prod[i] <= r_prod[i-1];
      if (w_accept && w_is_mul)    r_mul_cnt <= MC_W'(1);
      else if (w_mul_done)         r_mul_cnt <= '0;
      else if (r_state == MD_ST_MUL) r_mul_cnt <= r_mul_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_dbz     <= 1'b0;
      r_dvd_raw <= '0;
    end else if (w_accept && w_is_div) begin
      r_neg_q   <= w_div_sgn && (rsVal[31] ^ rtVal[31]);
      r_neg_r   <= w_div_sgn && rsVal[31];
      r_dbz     <= (rtVal == 32'd0);
      r_dvd_raw <= rsVal;
    end
  end

  // All writers are mutually exclusive: accepts only happen in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      if (w_accept && w_op == MD_MTHI) r_hi <= rsVal;
      if (w_accept && w_op == MD_MTLO) r_lo <= rsVal;
      if (w_mul_done) {r_hi, r_lo} <= r_prod[MUL_CYCLES-1];
      if (w_div_done) begin
        r_lo <= w_q_fix;
        r_hi <= w_r_fix;
      end
    end
  end

  assign busy      = (r_state != MD_ST_IDLE);
  assign stallRqEx = busy && (w_op != MD_NONE);

  always_comb begin
    mdResult = '0;
    if (w_op == MD_MFHI)      mdResult = r_hi;
    else if (w_op == MD_MFLO) mdResult = r_lo;
  end

endmodule
